// File: rtl/uart_audio_framer.sv
// uart_audio_framer: assembles little-endian, channel-interleaved PCM frames
// from a UART byte stream, buffers whole frames in a FIFO and releases one
// frame per internal sample tick on a parallel bus with a DAC clock enable.
//
// Optional feature macro: UART_AUDIO_FRAMER_SIGNED_EN
//   defined   -> input samples are two's complement; each channel MSB is
//                inverted on pop (offset binary out), reset value is midscale.
//   undefined -> samples pass through unmodified, reset value is 0.
//
// Handshake: rx_received qualifies rx_data for exactly one cycle and there is
// no back-pressure; every pulse is consumed in the cycle it is high. A frame
// that cannot be stored because the FIFO is full is dropped and flagged.
module uart_audio_framer #(
    parameter int BITS        = 16,
    parameter int CHANNELS    = 2,
    parameter int DEPTH       = 16,
    parameter int DIVIDE      = 250,
    parameter int IDLE_CYCLES = 1024
) (
    input  logic                       CLK_IN,
    input  logic                       reset,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_received,
    input  logic                       clear_flags,
    output logic [CHANNELS*BITS-1:0]   sample_out,
    output logic                       sample_ce,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       underrun,
    output logic                       overflow
);

    localparam int NB = BITS / 8;
    localparam int FW = CHANNELS * BITS;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(IDLE_CYCLES + 1);
    localparam int DW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;

    // One set bit at the top of every channel slot.
    localparam logic [FW-1:0] MSB_MASK = {CHANNELS{{1'b1, {(BITS-1){1'b0}}}}};
`ifdef UART_AUDIO_FRAMER_SIGNED_EN
    localparam logic [FW-1:0] OUT_XOR = MSB_MASK;
`else
    localparam logic [FW-1:0] OUT_XOR = '0;
`endif

    logic [1:0]    byte_idx;
    logic [2:0]    chan_idx;
    logic [FW-1:0] stage;
    logic [FW-1:0] stage_wr;
    logic [GW-1:0] gap_cnt;
    logic [DW-1:0] div_cnt;
    logic [FW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          last_byte;
    logic          frame_done;
    logic          fifo_full;
    logic          tick;
    logic          push;
    logic          pop;

    // Staging image with the current byte merged in; this is also the frame
    // pushed when the byte completes it.
    always_comb begin
        stage_wr = stage;
        stage_wr[int'(chan_idx)*BITS + int'(byte_idx)*8 +: 8] = rx_data;
    end

    // Frame completion, FIFO push/pop and tick decode.
    always_comb begin
        last_byte  = (byte_idx == 2'(NB-1)) && (chan_idx == 3'(CHANNELS-1));
        frame_done = rx_received && last_byte;
        fifo_full  = (fifo_level == LW'(DEPTH));
        tick       = (div_cnt == '0);
        push       = frame_done && !fifo_full;
        pop        = tick && (fifo_level != '0);
    end

    // Byte assembler with idle-gap resynchronisation of a partial frame.
    always_ff @(posedge CLK_IN or posedge reset) begin
        if (reset) begin
            byte_idx <= '0;
            chan_idx <= '0;
            stage    <= '0;
            gap_cnt  <= '0;
        end else if (rx_received) begin
            stage   <= stage_wr;
            gap_cnt <= '0;
            if (byte_idx == 2'(NB-1)) begin
                byte_idx <= '0;
                chan_idx <= (chan_idx == 3'(CHANNELS-1)) ? 3'd0 : chan_idx + 3'd1;
            end else begin
                byte_idx <= byte_idx + 2'd1;
            end
        end else if (gap_cnt != GW'(IDLE_CYCLES)) begin
            gap_cnt <= gap_cnt + GW'(1);
        end else if ((byte_idx != '0) || (chan_idx != '0)) begin
            byte_idx <= '0;
            chan_idx <= '0;
        end
    end

    // Sample-rate divider: down-counter, tick while it reads zero.
    always_ff @(posedge CLK_IN or posedge reset) begin
        if (reset) begin
            div_cnt <= DW'(DIVIDE-1);
        end else if (tick) begin
            div_cnt <= DW'(DIVIDE-1);
        end else begin
            div_cnt <= div_cnt - DW'(1);
        end
    end

    // FIFO storage; contents are invalidated by the pointer reset.
    always_ff @(posedge CLK_IN) begin
        if (push) begin
            mem[wr_ptr] <= stage_wr;
        end
    end

    // FIFO pointers and fill level.
    always_ff @(posedge CLK_IN or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Output register: head frame on a tick, hold on an empty tick.
    always_ff @(posedge CLK_IN or posedge reset) begin
        if (reset) begin
            sample_out <= OUT_XOR;
            sample_ce  <= 1'b0;
        end else begin
            sample_ce <= tick;
            if (pop) sample_out <= mem[rd_ptr] ^ OUT_XOR;
        end
    end

    // Sticky flags; a set event beats a simultaneous clear.
    always_ff @(posedge CLK_IN or posedge reset) begin
        if (reset) begin
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (tick && (fifo_level == '0)) underrun <= 1'b1;
            else if (clear_flags)           underrun <= 1'b0;
            if (frame_done && fifo_full)    overflow <= 1'b1;
            else if (clear_flags)           overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_audio_framer.sv
// Directed bench for uart_audio_framer at default parameters
// (BITS=16, CHANNELS=2, DEPTH=16, DIVIDE=250, IDLE_CYCLES=1024).
// Inputs change and outputs are sampled on the falling edge of CLK_IN.
module tb_uart_audio_framer;

    logic        CLK_IN;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_received;
    logic        clear_flags;
    logic [31:0] sample_out;
    logic        sample_ce;
    logic [4:0]  fifo_level;
    logic        underrun;
    logic        overflow;

    int tests;
    int failed;

    uart_audio_framer dut (
        .CLK_IN      (CLK_IN),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_received (rx_received),
        .clear_flags (clear_flags),
        .sample_out  (sample_out),
        .sample_ce   (sample_ce),
        .fifo_level  (fifo_level),
        .underrun    (underrun),
        .overflow    (overflow)
    );

    // Clock: 10 ns period.
    initial CLK_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;

    // Expected output image of a raw little-endian frame.
    function automatic logic [31:0] xo(input logic [31:0] raw);
`ifdef UART_AUDIO_FRAMER_SIGNED_EN
        return raw ^ 32'h8000_8000;
`else
        return raw;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; drives one byte for one cycle.
    task automatic send_byte(input logic [7:0] b);
        rx_data     = b;
        rx_received = 1'b1;
        @(negedge CLK_IN);
        rx_received = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    // Wait for the next falling edge with sample_ce high; n = edges waited.
    task automatic wait_ce(output int n);
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge CLK_IN);
            if (sample_ce) begin
                n = i;
                break;
            end
        end
        check("ce_seen", 32'(n != 0), 32'd1);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(negedge CLK_IN);
        clear_flags = 1'b0;
    endtask

    initial begin
        int n;
        tests       = 0;
        failed      = 0;
        rx_data     = 8'h00;
        rx_received = 1'b0;
        clear_flags = 1'b0;
        reset       = 1'b1;

        // Reset state
        repeat (3) @(negedge CLK_IN);
        check("rst_out",   sample_out, xo(32'h0000_0000));
        check("rst_ce",    32'(sample_ce), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_under", 32'(underrun), 32'd0);
        check("rst_over",  32'(overflow), 32'd0);

        // Tick spacing and underrun on empty FIFO
        reset = 1'b0;
        wait_ce(n);
        check("first_tick_gap", 32'(n), 32'd250);
        check("empty_under", 32'(underrun), 32'd1);
        check("empty_hold", sample_out, xo(32'h0000_0000));
        wait_ce(n);
        check("tick_gap", 32'(n), 32'd250);
        pulse_clear();
        check("clear_under", 32'(underrun), 32'd0);

        // Basic stream: 34 12 78 56
        wait_ce(n);
        pulse_clear();
        send_frame(8'h34, 8'h12, 8'h78, 8'h56);
        check("basic_lvl1", 32'(fifo_level), 32'd1);
        wait_ce(n);
        check("basic_out", sample_out, xo(32'h5678_1234));
        check("basic_lvl0", 32'(fifo_level), 32'd0);
        check("basic_under", 32'(underrun), 32'd0);
        @(negedge CLK_IN);
        check("basic_ce_single", 32'(sample_ce), 32'd0);

        // Underrun after one frame 0x1111_2222
        send_frame(8'h22, 8'h22, 8'h11, 8'h11);
        wait_ce(n);
        check("ur_out", sample_out, xo(32'h1111_2222));
        check("ur_flag0", 32'(underrun), 32'd0);
        wait_ce(n);
        check("ur_hold", sample_out, xo(32'h1111_2222));
        check("ur_flag1", 32'(underrun), 32'd1);
        pulse_clear();
        check("ur_clear", 32'(underrun), 32'd0);

        // Clear in the same cycle as an empty tick: set wins
        wait_ce(n);
        pulse_clear();
        repeat (248) @(negedge CLK_IN);
        clear_flags = 1'b1;
        @(negedge CLK_IN);
        clear_flags = 1'b0;
        check("setwins_ce", 32'(sample_ce), 32'd1);
        check("setwins_under", 32'(underrun), 32'd1);
        pulse_clear();

        // Short gap keeps the partial frame
        wait_ce(n);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (500) @(negedge CLK_IN);
        send_byte(8'h33);
        send_byte(8'h44);
        wait_ce(n);
        check("shortgap_out", sample_out, xo(32'h4433_2211));

        // Resync: 3 bytes, long idle, then a clean frame
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        repeat (1100) @(negedge CLK_IN);
        wait_ce(n);
        send_frame(8'hAA, 8'h00, 8'hBB, 8'h00);
        check("resync_lvl", 32'(fifo_level), 32'd1);
        wait_ce(n);
        check("resync_out", sample_out, xo(32'h00BB_00AA));

        // Push in the same cycle as a tick with one frame stored
        wait_ce(n);
        send_frame(8'h01, 8'hC0, 8'h02, 8'hC0);
        check("pot_lvl_pre", 32'(fifo_level), 32'd1);
        repeat (242) @(negedge CLK_IN);
        send_frame(8'h03, 8'hD0, 8'h04, 8'hD0);
        check("pot_ce", 32'(sample_ce), 32'd1);
        check("pot_out_old", sample_out, xo(32'hC002_C001));
        check("pot_lvl", 32'(fifo_level), 32'd1);
        wait_ce(n);
        check("pot_out_new", sample_out, xo(32'hD004_D003));
        check("pot_lvl0", 32'(fifo_level), 32'd0);

        // Overflow: 17 frames between ticks
        wait_ce(n);
        pulse_clear();
        for (int i = 1; i <= 16; i++) begin
            send_frame(8'(i), 8'hA0, 8'(i), 8'hB0);
        end
        check("ovf_lvl16", 32'(fifo_level), 32'd16);
        check("ovf_flag0", 32'(overflow), 32'd0);
        send_frame(8'd17, 8'hA0, 8'd17, 8'hB0);
        check("ovf_lvl_full", 32'(fifo_level), 32'd16);
        check("ovf_flag1", 32'(overflow), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            wait_ce(n);
            check($sformatf("ovf_pop%0d", i), sample_out,
                  xo({8'hB0, 8'(i), 8'hA0, 8'(i)}));
            check($sformatf("ovf_lvl%0d", i), 32'(fifo_level), 32'(16 - i));
        end
        wait_ce(n);
        check("ovf_no17", sample_out, xo(32'hB010_A010));
        check("ovf_under", 32'(underrun), 32'd1);
        pulse_clear();
        check("ovf_clear", 32'(overflow), 32'd0);

        // Signed sample values: 00 80 FF 7F
        wait_ce(n);
        send_frame(8'h00, 8'h80, 8'hFF, 8'h7F);
        wait_ce(n);
`ifdef UART_AUDIO_FRAMER_SIGNED_EN
        check("signed_out", sample_out, 32'hFFFF_0000);
`else
        check("signed_out", sample_out, 32'h7FFF_8000);
`endif

        // Reset mid-frame drops FIFO and partial frame
        send_frame(8'h01, 8'h01, 8'h01, 8'h01);
        send_byte(8'h99);
        send_byte(8'h98);
        reset = 1'b1;
        @(negedge CLK_IN);
        check("midrst_lvl", 32'(fifo_level), 32'd0);
        check("midrst_out", sample_out, xo(32'h0000_0000));
        reset = 1'b0;
        send_frame(8'h55, 8'h66, 8'h77, 8'h88);
        check("midrst_lvl1", 32'(fifo_level), 32'd1);
        wait_ce(n);
        check("midrst_gap", 32'(n), 32'd246);
        check("midrst_frame", sample_out, xo(32'h8877_6655));
        check("midrst_lvl0", 32'(fifo_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
